// File: rtl/saes_pkg.sv
// Shared definitions for the masked S-AES nibble sequencer.
//   NIB_W/STATE_W/NUM_NIB/IDX_W : datapath geometry
//   state_t                     : sequencer FSM encoding
//   nib_sel / nib_ins           : MSB-first nibble extract / insert
package saes_pkg;

    localparam int NIB_W   = 4;
    localparam int STATE_W = 16;
    localparam int NUM_NIB = 4;
    localparam int IDX_W   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    // k=0 is the most significant nibble.
    function automatic logic [NIB_W-1:0] nib_sel(input logic [STATE_W-1:0] s,
                                                  input logic [IDX_W-1:0]   k);
        case (k)
            2'd0:    return s[15:12];
            2'd1:    return s[11:8];
            2'd2:    return s[7:4];
            default: return s[3:0];
        endcase
    endfunction

    function automatic logic [STATE_W-1:0] nib_ins(input logic [STATE_W-1:0] s,
                                                    input logic [IDX_W-1:0]   k,
                                                    input logic [NIB_W-1:0]   n);
        logic [STATE_W-1:0] r;
        r = s;
        case (k)
            2'd0:    r[15:12] = n;
            2'd1:    r[11:8]  = n;
            2'd2:    r[7:4]   = n;
            default: r[3:0]   = n;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lat_valid_pipe.sv
// Valid/index delay line matching the SBox latency. Carries control only,
// so one instance serves both shares.
//   clk, rst        : clock, synchronous active-high clear
//   in_vld, in_idx  : a nibble is on the SBox inputs this cycle, and its index
//   out_vld, out_idx: the SBox outputs this cycle belong to nibble out_idx
module lat_valid_pipe
    import saes_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_vld,
    output logic [IDX_W-1:0] out_idx
);

    logic [DEPTH-1:0] vld_q;
    logic [IDX_W-1:0] idx_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) idx_q[i] <= '0;
        end else begin
            vld_q[0] <= in_vld;
            idx_q[0] <= in_idx;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
        end
    end

    assign out_vld = vld_q[DEPTH-1];
    assign out_idx = idx_q[DEPTH-1];

endmodule

// File: rtl/masked_subnib_seq.sv
// Feeds a two-share masked 16-bit state to a single DOM SBox one nibble
// pair per cycle and reassembles the substituted shares.
//   clk, rst           : clock, synchronous active-high reset
//   start              : request, only honoured in IDLE
//   a_in, b_in         : input shares
//   sb_a, sb_b         : nibble pair to the SBox (0 when not issuing)
//   sb_a_out, sb_b_out : SBox output shares, SBOX_LAT cycles later
//   a_out, b_out       : substituted shares, valid at done
//   busy, done         : FEED/DRAIN indicator, one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for start, SBox inputs held at 0
// FEED  | nibbles 0..3 on the SBox inputs, one per cycle
// DRAIN | SBox inputs at 0, waiting for the last output capture
// FIN   | done pulse, back to IDLE
module masked_subnib_seq #(
    parameter int SBOX_LAT = 2,
    parameter int NUM_NIB  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a_in,
    input  logic [15:0] b_in,
    output logic [3:0]  sb_a,
    output logic [3:0]  sb_b,
    input  logic [3:0]  sb_a_out,
    input  logic [3:0]  sb_b_out,
    output logic [15:0] a_out,
    output logic [15:0] b_out,
    output logic        busy,
    output logic        done
);
    import saes_pkg::*;

    if (SBOX_LAT < 1 || SBOX_LAT > 6) begin : g_bad_lat
        $error("SBOX_LAT must be in 1..6");
    end
    if (NUM_NIB != 4) begin : g_bad_nib
        $error("NUM_NIB must be 4");
    end

    state_t             state_q, state_d;
    logic [STATE_W-1:0] sh_a, sh_b;
    logic               iss_vld;
    logic [IDX_W-1:0]   iss_idx, nxt_idx, cap_cnt, pv_idx;
    logic               pv_vld, accept, issue, last_cap;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        issue    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        last_cap = pv_vld && (pv_idx == IDX_W'(NUM_NIB - 1));
        nxt_idx  = iss_idx + 1'b1;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    issue   = 1'b1;
                    nxt_idx = '0;
                    state_d = FEED;
                end
            end
            FEED: begin
                busy = 1'b1;
                if (iss_idx == IDX_W'(NUM_NIB - 1)) state_d = DRAIN;
                else                                issue   = 1'b1;
            end
            DRAIN: begin
                busy = 1'b1;
                if (last_cap) state_d = FIN;
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Issue control, shared by both shares (no share data here).
    always_ff @(posedge clk) begin
        if (rst) begin
            iss_vld <= 1'b0;
            iss_idx <= '0;
            cap_cnt <= '0;
        end else begin
            iss_vld <= issue;
            if (issue)       iss_idx <= nxt_idx;
            if (accept)      cap_cnt <= '0;
            else if (pv_vld) cap_cnt <= cap_cnt + 1'b1;
        end
    end

    // Share A datapath. Non-issue cycles drive 0 so no stale share value
    // ever toggles onto the SBox input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_a  <= '0;
            sb_a  <= '0;
            a_out <= '0;
        end else begin
            if (accept) sh_a <= a_in;
            sb_a <= issue ? nib_sel(accept ? a_in : sh_a, nxt_idx) : '0;
            if (pv_vld) a_out <= nib_ins(a_out, cap_cnt, sb_a_out);
        end
    end

    // Share B datapath, kept structurally separate from share A.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_b  <= '0;
            sb_b  <= '0;
            b_out <= '0;
        end else begin
            if (accept) sh_b <= b_in;
            sb_b <= issue ? nib_sel(accept ? b_in : sh_b, nxt_idx) : '0;
            if (pv_vld) b_out <= nib_ins(b_out, cap_cnt, sb_b_out);
        end
    end

    lat_valid_pipe #(.DEPTH(SBOX_LAT)) u_pipe (
        .clk    (clk),
        .rst    (rst),
        .in_vld (iss_vld),
        .in_idx (iss_idx),
        .out_vld(pv_vld),
        .out_idx(pv_idx)
    );

endmodule

// File: tb/tb_masked_subnib_seq.sv
module tb_masked_subnib_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start1 = 1'b0, start2 = 1'b0;
    logic [15:0] a_in = '0, b_in = '0;
    logic [3:0]  sb_a1, sb_b1, sb_a2, sb_b2;
    logic [3:0]  sb_a_out1 = '0, sb_b_out1 = '0, sb_a_out2 = '0, sb_b_out2 = '0;
    logic [15:0] a_out1, b_out1, a_out2, b_out2;
    logic        busy1, done1, busy2, done2;

    int n_chk  = 0;
    int n_fail = 0;
    logic sel = 1'b0;

    always #5 clk = ~clk;

    masked_subnib_seq #(.SBOX_LAT(2), .NUM_NIB(4)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a_in(a_in), .b_in(b_in),
        .sb_a(sb_a1), .sb_b(sb_b1), .sb_a_out(sb_a_out1), .sb_b_out(sb_b_out1),
        .a_out(a_out1), .b_out(b_out1), .busy(busy1), .done(done1));

    masked_subnib_seq #(.SBOX_LAT(4), .NUM_NIB(4)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a_in(a_in), .b_in(b_in),
        .sb_a(sb_a2), .sb_b(sb_b2), .sb_a_out(sb_a_out2), .sb_b_out(sb_b_out2),
        .a_out(a_out2), .b_out(b_out2), .busy(busy2), .done(done2));

    wire [3:0]  o_sb_a  = sel ? sb_a2  : sb_a1;
    wire [3:0]  o_sb_b  = sel ? sb_b2  : sb_b1;
    wire [15:0] o_a_out = sel ? a_out2 : a_out1;
    wire [15:0] o_b_out = sel ? b_out2 : b_out1;
    wire        o_busy  = sel ? busy2  : busy1;
    wire        o_done  = sel ? done2  : done1;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: return 4'h9; 4'h1: return 4'h4; 4'h2: return 4'hA; 4'h3: return 4'hB;
            4'h4: return 4'hD; 4'h5: return 4'h1; 4'h6: return 4'h8; 4'h7: return 4'h5;
            4'h8: return 4'h6; 4'h9: return 4'h2; 4'hA: return 4'h0; 4'hB: return 4'h3;
            4'hC: return 4'hC; 4'hD: return 4'hE; 4'hE: return 4'hF; default: return 4'h7;
        endcase
    endfunction

    function automatic logic [3:0] nib(input logic [15:0] s, input int k);
        return 4'((s >> (12 - 4 * k)) & 16'hF);
    endfunction

    function automatic logic [15:0] sub_word(input logic [15:0] x);
        logic [15:0] r = '0;
        for (int k = 0; k < 4; k++) r = (r << 4) | 16'(sbox(nib(x, k)));
        return r;
    endfunction

    // Behavioural masked SBox: unmask, substitute, remask with fresh B.
    // Entry j of each history holds the output for the input seen j cycles ago.
    logic [3:0] ha1 [8], hb1 [8], ha2 [8], hb2 [8];
    initial for (int i = 0; i < 8; i++) begin ha1[i] = 0; hb1[i] = 0; ha2[i] = 0; hb2[i] = 0; end

    always @(negedge clk) begin
        logic [3:0] r1, r2;
        for (int i = 7; i > 0; i--) begin
            ha1[i] = ha1[i-1]; hb1[i] = hb1[i-1];
            ha2[i] = ha2[i-1]; hb2[i] = hb2[i-1];
        end
        r1 = 4'($urandom); r2 = 4'($urandom);
        hb1[0] = r1; ha1[0] = sbox(sb_a1 ^ sb_b1) ^ r1;
        hb2[0] = r2; ha2[0] = sbox(sb_a2 ^ sb_b2) ^ r2;
        sb_a_out1 = ha1[2]; sb_b_out1 = hb1[2];
        sb_a_out2 = ha2[4]; sb_b_out2 = hb2[4];
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) start2 = v; else start1 = v;
    endtask

    // Start in the current cycle t0; returns at the negedge of the done cycle.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int stray,
                          input bit fin_start);
        int lat    = sel ? 4 : 2;
        int done_n = -1;
        a_in = a; b_in = b;
        set_start(1'b1);
        for (int n = 1; n <= lat + 10; n++) begin
            @(negedge clk);
            set_start(1'b0);
            if (n == stray) begin
                set_start(1'b1);
                a_in = 16'($urandom); b_in = 16'($urandom);
            end
            if (n <= 4) begin
                chk_eq("sb_a_nib", o_sb_a, nib(a, n - 1));
                chk_eq("sb_b_nib", o_sb_b, nib(b, n - 1));
            end else begin
                chk_eq("sb_a_gap", o_sb_a, 0);
                chk_eq("sb_b_gap", o_sb_b, 0);
            end
            if (n == 1) chk_eq("busy_rise", o_busy, 1);
            if (o_done) begin
                done_n = n;
                chk_eq("busy_at_done", o_busy, 0);
                chk_eq("result", o_a_out ^ o_b_out, sub_word(a ^ b));
                if (fin_start) set_start(1'b1);
                break;
            end
        end
        chk_eq("done_cycle", done_n, lat + 5);
    endtask

    task automatic quiet(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk_eq("no_done", o_done, 0);
            chk_eq("idle_busy", o_busy, 0);
            chk_eq("idle_sb_a", o_sb_a, 0);
            chk_eq("idle_sb_b", o_sb_b, 0);
        end
    endtask

    initial begin
        logic [15:0] ra, rb, hold;
        bit nsel, fs;
        int st;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_eq("rst_sb", {sb_a1, sb_b1, sb_a2, sb_b2}, 0);
        chk_eq("rst_out1", {a_out1, b_out1}, 0);
        chk_eq("rst_out2", {a_out2, b_out2}, 0);
        chk_eq("rst_flags", {busy1, done1, busy2, done2}, 0);

        sel = 0;
        run_op(16'h0123, 16'h0000, 0, 0);
        chk_eq("res_0123", a_out1 ^ b_out1, 16'h94AB);
        quiet(2);
        run_op(16'h3C3C, 16'h99CC, 0, 0);
        chk_eq("res_a5f0", a_out1 ^ b_out1, 16'h0179);
        quiet(2);
        run_op(16'h3C3C, 16'h99CC, 3, 0);
        chk_eq("res_stray", a_out1 ^ b_out1, 16'h0179);
        hold = a_out1;
        quiet(6);
        chk_eq("hold_a_out", a_out1, hold);

        // abort at t0+4
        a_in = 16'h1234; b_in = 16'h5678; start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_eq("abort_busy", busy1, 0);
        chk_eq("abort_done", done1, 0);
        chk_eq("abort_out", {a_out1, b_out1}, 0);
        chk_eq("abort_sb", {sb_a1, sb_b1}, 0);
        quiet(6);
        chk_eq("abort_out_kept", {a_out1, b_out1}, 0);
        run_op(16'hFFFF, 16'h0000, 0, 0);
        chk_eq("res_ffff", a_out1 ^ b_out1, 16'h7777);

        // back-to-back: next start in the cycle after done
        @(negedge clk);
        run_op(16'hFEDC, 16'h0000, 0, 0);
        chk_eq("res_fedc", a_out1 ^ b_out1, 16'h7FEC);
        quiet(2);

        sel = 1;
        run_op(16'h0123, 16'h0000, 0, 0);
        chk_eq("res_lat4", a_out2 ^ b_out2, 16'h94AB);
        quiet(2);

        // random: start held through FIN must only be taken from IDLE
        nsel = 1'($urandom_range(0, 1));
        for (int t = 0; t < 12; t++) begin
            sel = nsel;
            nsel = 1'($urandom_range(0, 1));
            ra = 16'($urandom); rb = 16'($urandom);
            st = $urandom_range(0, 1) ? $urandom_range(1, (sel ? 4 : 2) + 4) : 0;
            fs = (nsel == sel) && ($urandom_range(0, 1) == 1);
            run_op(ra, rb, st, fs);
            if (fs) @(negedge clk);
            else    quiet(1);
        end
        start1 = 0; start2 = 0;
        quiet(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/masked_subnib_seq.md
Name: masked_subnib_seq

Overview:
- Sequencer directly upstream of the DOM-masked S-AES SBox, and the consumer of its outputs.
- Accepts a 16-bit two-share masked state (A share, B share) and issues one nibble pair per cycle to the single SBox instance.
- Collects the SBox output shares after the pipeline latency and reassembles the substituted 16-bit shares.
- Randomness (Z*, Az*, Bz*) is wired from the top straight to the SBox; this block never touches it.

Parameters:
- SBOX_LAT, 2, SBox input-to-output latency in clk cycles; legal range 1..6.
- NUM_NIB, 4, nibbles per state; fixed at 4 for S-AES, exists only for elaboration checks.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only while busy=0
- a_in  in  16  share A of input state
- b_in  in  16  share B of input state
- sb_a  out  4  nibble of share A to SBox A
- sb_b  out  4  nibble of share B to SBox B
- sb_a_out  in  4  SBox A_out
- sb_b_out  in  4  SBox B_out
- a_out  out  16  substituted share A, held until next start
- b_out  out  16  substituted share B
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  one-cycle pulse when a_out/b_out are complete

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: sb_a=0, sb_b=0, a_out=0, b_out=0, busy=0, done=0. FSM goes to IDLE, counters go to 0, valid pipe is cleared.
- Nibble order: k=0 is bits[15:12] and k=3 is bits[3:0]. Output reassembly uses the same order.
- FSM states: IDLE, FEED, DRAIN, FIN.
- IDLE: sb_a and sb_b are driven 0. On start=1 at edge t0:
  - latch a_in and b_in into internal share registers;
  - go to FEED;
  - register nibble 0 onto sb_a/sb_b, visible in cycle t0+1.
- FEED: nibble k is visible on sb_a/sb_b in cycle t0+1+k, k=0..3. After nibble 3 is issued, go to DRAIN and drive sb_a/sb_b to 0 from cycle t0+5.
- Valid pipe: a SBOX_LAT-deep shift register tags each issued nibble with its index.
  - The output for nibble k is captured at the end of cycle t0+1+k+SBOX_LAT into a_out/b_out at slot k.
  - A separate capture counter selects the slot.
- DRAIN: after the capture of nibble 3, go to FIN.
- FIN: done=1 for exactly one cycle, in cycle t0+5+SBOX_LAT; busy falls in the same cycle; then IDLE.
- done and busy: busy=1 during FEED and DRAIN, 0 in FIN and IDLE.
- start while busy=1 is ignored; no queueing.
- start in the FIN cycle is ignored. It is accepted from IDLE on the next cycle.
- a_out/b_out: slots update progressively during an operation. Only the values present at the done pulse are valid. They hold until the next operation's first capture.
- Reset mid-operation: abort immediately.
  - All outputs return to reset values on the next edge.
  - No done is emitted.
  - In-flight SBox outputs are discarded because the valid pipe is cleared.
- Masking rules:
  - Shares A and B are never combined (no XOR, mux or shared register across shares).
  - A and B datapaths use separate registers.
  - Idle and gap cycles drive 0, never a previous share value, to avoid transition leakage onto the SBox inputs.
- Width: all nibble paths are 4 bits. No arithmetic beyond 3-bit counters, with no wrap beyond NUM_NIB.

Decomposition:
- Package saes_pkg holds:
  - NIB_W=4, STATE_W=16, NUM_NIB=4;
  - the FSM state enum {IDLE, FEED, DRAIN, FIN};
  - a function nib_sel(state, k) returning the nibble at index k (MSB-first).
- Sub-module lat_valid_pipe (parameter DEPTH=SBOX_LAT): valid bit plus 2-bit index shift register with synchronous clear. It is instantiated once and shared by both shares, since it carries control only and no share data.

Test Plan:
The bench uses a behavioural SBox model applying the S-AES SBox to the unmasked value (A^B) with latency SBOX_LAT=2, re-splitting the result with fresh random B.
- Reset, then a_in=0x0123, b_in=0x0000, start at t0 -> done only in cycle t0+7; a_out^b_out=0x94AB; sb_a sequence 0,1,2,3 in cycles t0+1..t0+4, then 0.
- a_in=0x3C3C, b_in=0x99CC (unmasked 0xA5F0) -> a_out^b_out=0x0179; sb_b sequence 9,9,C,C.
- Second start pulsed at t0+3 during an operation -> ignored; a single done; result unchanged (0x0179).
- rst asserted at t0+4 -> next cycle: busy=0, a_out=b_out=0, sb_a=sb_b=0, no done. Then a new start with 0xFFFF/0x0000 -> 0x7777.
- Back-to-back: start asserted again in the cycle after done -> second operation completes correctly (check 0xFEDC/0x0000 -> 0x7FEC). Idle sb_a/sb_b are 0 between operations.
- SBOX_LAT=4 rerun of the first scenario -> done in cycle t0+9 with the same 0x94AB.
